// File: rtl/trdb_stream_mux.sv
// -----------------------------------------------------------------------------
// trdb_stream_mux
//
// Merges the trace packet stream and the software dump stream into a single
// word stream for the packet streamer. One output register holds the merged
// word. Grants are combinational and issued only when that register is free,
// so a granted word appears on out_word_o one cycle later. A small flush FSM
// tracks stream drain and returns a one-cycle completion pulse.
//
// Optional feature (macro TRDB_STREAM_MUX_FAIRNESS_EN):
//   undefined : strict packet priority, MAX_BURST is ignored.
//   defined   : after MAX_BURST consecutive packet grants with a software
//               word waiting, the software word takes the next free slot.
//
// Parameters:
//   MAX_BURST        packet grants allowed while a software word waits (1..255)
//
// Ports:
//   clk_i            clock, rising edge
//   rst_ni           asynchronous active-low reset
//   pkt_word_i       trace packet word
//   pkt_valid_i      pkt_word_i is valid
//   pkt_grant_o      packet word consumed this cycle
//   sw_word_i        software dump word
//   sw_valid_i       sw_word_i is valid
//   sw_grant_o       software word consumed this cycle
//   flush_stream_i   flush request
//   flush_confirm_o  one-cycle flush-complete pulse
//   out_word_o       merged stream word
//   out_src_o        source of out_word_o (0 = packet, 1 = software)
//   out_valid_o      out_word_o / out_src_o valid
//   out_ready_i      downstream accepts the word when high with out_valid_o
// -----------------------------------------------------------------------------
module trdb_stream_mux #(
    parameter int MAX_BURST = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] pkt_word_i,
    input  logic        pkt_valid_i,
    output logic        pkt_grant_o,
    input  logic [31:0] sw_word_i,
    input  logic        sw_valid_i,
    output logic        sw_grant_o,
    input  logic        flush_stream_i,
    output logic        flush_confirm_o,
    output logic [31:0] out_word_o,
    output logic        out_src_o,
    output logic        out_valid_o,
    input  logic        out_ready_i
);

    // Reject out-of-range burst limits at elaboration time.
    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_max_burst_range
        $error("trdb_stream_mux: MAX_BURST must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAIN   = 2'd1,
        CONFIRM = 2'd2
    } flush_state_t;

    flush_state_t flush_state;

    logic slot_free;
    logic pkt_win;
    logic sw_win;
    logic pkt_take;
    logic sw_take;

    // The slot is free when empty or when its word leaves this cycle.
    assign slot_free = ~out_valid_o | out_ready_i;

`ifdef TRDB_STREAM_MUX_FAIRNESS_EN
    localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

    logic [7:0] burst_cnt;
    logic       sw_turn;

    // Software gets priority once the packet burst limit has been reached.
    assign sw_turn = sw_valid_i & (burst_cnt == MAX_BURST_C);

    always_comb begin
        pkt_win = pkt_valid_i & ~sw_turn;
        sw_win  = sw_valid_i & (~pkt_valid_i | sw_turn);
    end

    // Counts packet grants taken while software is waiting. It cannot pass
    // MAX_BURST because packets lose arbitration at that value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            burst_cnt <= 8'd0;
        end else if (!sw_valid_i || sw_take) begin
            burst_cnt <= 8'd0;
        end else if (pkt_take) begin
            burst_cnt <= burst_cnt + 8'd1;
        end
    end
`else
    always_comb begin
        pkt_win = pkt_valid_i;
        sw_win  = sw_valid_i & ~pkt_valid_i;
    end
`endif

    assign pkt_take = slot_free & pkt_win;
    assign sw_take  = slot_free & sw_win;

    // The visible grants are additionally forced low during reset; the
    // internal take signals drive the registers, which reset on their own.
    assign pkt_grant_o = pkt_take & rst_ni;
    assign sw_grant_o  = sw_take & rst_ni;

    // Output register: loads on a grant, empties when the word is accepted
    // with nothing new granted, holds otherwise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_o <= 1'b0;
            out_word_o  <= 32'd0;
            out_src_o   <= 1'b0;
        end else if (pkt_take) begin
            out_valid_o <= 1'b1;
            out_word_o  <= pkt_word_i;
            out_src_o   <= 1'b0;
        end else if (sw_take) begin
            out_valid_o <= 1'b1;
            out_word_o  <= sw_word_i;
            out_src_o   <= 1'b1;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

    // Flush tracking. Arbitration above never looks at this state, so a
    // flush only observes the stream; it never blocks it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flush_state     <= IDLE;
            flush_confirm_o <= 1'b0;
        end else begin
            flush_confirm_o <= 1'b0;
            case (flush_state)
                IDLE: begin
                    if (flush_stream_i) begin
                        flush_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The request level no longer matters once draining.
                    if (!pkt_valid_i && !sw_valid_i && !out_valid_o) begin
                        flush_state     <= CONFIRM;
                        flush_confirm_o <= 1'b1;
                    end
                end
                CONFIRM: begin
                    flush_state <= IDLE;
                end
                default: begin
                    flush_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trdb_stream_mux.sv
module tb_trdb_stream_mux;

    localparam int MB = 4;
`ifdef TRDB_STREAM_MUX_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [31:0] pkt_word;
    logic        pkt_valid;
    logic        pkt_grant;
    logic [31:0] sw_word;
    logic        sw_valid;
    logic        sw_grant;
    logic        flush;
    logic        confirm;
    logic [31:0] out_word;
    logic        out_src;
    logic        out_valid;
    logic        out_ready;

    int checks   = 0;
    int failures = 0;

    trdb_stream_mux #(.MAX_BURST(MB)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .pkt_word_i     (pkt_word),
        .pkt_valid_i    (pkt_valid),
        .pkt_grant_o    (pkt_grant),
        .sw_word_i      (sw_word),
        .sw_valid_i     (sw_valid),
        .sw_grant_o     (sw_grant),
        .flush_stream_i (flush),
        .flush_confirm_o(confirm),
        .out_word_o     (out_word),
        .out_src_o      (out_src),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: what the merged stream must hold, how many
    // packet grants software has waited through, and where the flush is.
    bit          m_valid;
    bit   [31:0] m_word;
    bit          m_src;
    int          m_wait;
    int          m_phase;   // 0 idle, 1 draining, 2 confirming

    always @(negedge clk) begin
        bit free, sw_first, e_pg, e_sg;
        if (!rst_ni) begin
            chk("rst_pkt_grant", {31'd0, pkt_grant}, 32'd0);
            chk("rst_sw_grant", {31'd0, sw_grant}, 32'd0);
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_out_word", out_word, 32'd0);
            chk("rst_out_src", {31'd0, out_src}, 32'd0);
            chk("rst_confirm", {31'd0, confirm}, 32'd0);
            m_valid = 0; m_word = 0; m_src = 0; m_wait = 0; m_phase = 0;
        end else begin
            free     = !m_valid || out_ready;
            sw_first = FAIR && sw_valid && (m_wait == MB);
            e_pg     = free && pkt_valid && !sw_first;
            e_sg     = free && sw_valid && (!pkt_valid || sw_first);
            chk("pkt_grant", {31'd0, pkt_grant}, {31'd0, e_pg});
            chk("sw_grant", {31'd0, sw_grant}, {31'd0, e_sg});
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            chk("confirm", {31'd0, confirm}, {31'd0, (m_phase == 2)});
            if (m_valid) begin
                chk("out_word", out_word, m_word);
                chk("out_src", {31'd0, out_src}, {31'd0, m_src});
            end
            case (m_phase)
                0: if (flush) m_phase = 1;
                1: if (!pkt_valid && !sw_valid && !m_valid) m_phase = 2;
                default: m_phase = 0;
            endcase
            if (!sw_valid || e_sg) m_wait = 0;
            else if (e_pg) m_wait = m_wait + 1;
            if (e_pg) begin
                m_valid = 1; m_word = pkt_word; m_src = 0;
            end else if (e_sg) begin
                m_valid = 1; m_word = sw_word; m_src = 1;
            end else if (out_ready) begin
                m_valid = 0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int conf_cnt;
        int conf_k;
        bit exp_sw;

        rst_ni = 0; pkt_word = 0; pkt_valid = 0; sw_word = 0; sw_valid = 0;
        flush = 0; out_ready = 0;
        #3;
        chk("init_out_valid", {31'd0, out_valid}, 32'd0);
        chk("init_out_word", out_word, 32'd0);
        chk("init_confirm", {31'd0, confirm}, 32'd0);
        repeat (3) cyc();

        // Packet beats software; first grant right after reset release.
        rst_ni = 1; out_ready = 1;
        pkt_valid = 1; pkt_word = 32'hAAAA_0001;
        sw_valid = 1; sw_word = 32'h5555_0002;
        #2;
        chk("prio_pkt_grant", {31'd0, pkt_grant}, 32'd1);
        chk("prio_sw_grant", {31'd0, sw_grant}, 32'd0);
        cyc();
        pkt_valid = 0; sw_valid = 0;
        #2;
        chk("prio_word", out_word, 32'hAAAA_0001);
        chk("prio_src", {31'd0, out_src}, 32'd0);
        cyc();

        // Held output under back-pressure.
        pkt_valid = 1; pkt_word = 32'hDEAD_BEEF;
        cyc();
        pkt_word = 32'h1234_5678; out_ready = 0;
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("hold_word", out_word, 32'hDEAD_BEEF);
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_no_grant", {31'd0, pkt_grant}, 32'd0);
            cyc();
        end
        out_ready = 1;
        #2;
        chk("release_grant", {31'd0, pkt_grant}, 32'd1);
        cyc();
        pkt_valid = 0;
        #2;
        chk("release_word", out_word, 32'h1234_5678);
        cyc();
        cyc();

        // Both sources continuously valid.
        pkt_valid = 1; sw_valid = 1;
        for (int i = 0; i < 15; i++) begin
            pkt_word = 32'h1000 + i; sw_word = 32'h2000 + i;
            #2;
            exp_sw = FAIR && ((i % 5) == 4);
            chk("burst_sw_grant", {31'd0, sw_grant}, {31'd0, exp_sw});
            chk("burst_pkt_grant", {31'd0, pkt_grant}, {31'd0, !exp_sw});
            cyc();
        end
        pkt_valid = 0; sw_valid = 0;
        cyc();
        cyc();

        // Flush with two packet words pending.
        pkt_valid = 1; pkt_word = 32'hF1F1_0001; flush = 1;
        cyc();
        pkt_word = 32'hF1F1_0002; flush = 0;
        cyc();
        pkt_valid = 0;
        conf_cnt = 0; conf_k = -1;
        for (int k = 0; k < 6; k++) begin
            #2;
            if (k == 0) chk("flush_last_word", out_word, 32'hF1F1_0002);
            if (confirm) begin
                conf_cnt++;
                conf_k = k;
                chk("flush_valid_low", {31'd0, out_valid}, 32'd0);
            end
            cyc();
        end
        chk("flush_pulse_count", conf_cnt, 32'd1);
        chk("flush_pulse_cycle", conf_k, 32'd2);

        // Reset while draining with a word held.
        pkt_valid = 1; pkt_word = 32'hCAFE_F00D; flush = 1; out_ready = 0;
        cyc();
        pkt_valid = 0; flush = 0;
        #1;
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        pkt_valid = 1; rst_ni = 0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_word", out_word, 32'd0);
        chk("arst_src", {31'd0, out_src}, 32'd0);
        chk("arst_pkt_grant", {31'd0, pkt_grant}, 32'd0);
        chk("arst_confirm", {31'd0, confirm}, 32'd0);
        cyc();
        cyc();
        rst_ni = 1; pkt_valid = 0; out_ready = 1;
        conf_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            #2;
            if (confirm) conf_cnt++;
            cyc();
        end
        chk("no_confirm_after_rst", conf_cnt, 32'd0);

        // Randomised traffic with occasional flushes and resets.
        for (int i = 0; i < 3000; i++) begin
            if (((i / 300) % 2) == 0) begin
                pkt_valid = ($urandom_range(0, 3) != 0);
                sw_valid  = ($urandom_range(0, 2) != 0);
            end else begin
                pkt_valid = ($urandom_range(0, 3) == 0);
                sw_valid  = ($urandom_range(0, 3) == 0);
            end
            pkt_word  = $urandom;
            sw_word   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            rst_ni    = ($urandom_range(0, 399) != 0);
            cyc();
        end
        rst_ni = 1; pkt_valid = 0; sw_valid = 0; flush = 0;
        cyc();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
